// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: streams two operand vectors from banks A/B into a pipelined MAC
// and captures the final psum behind a valid/ready handshake.
module mac_dot_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 11,
  parameter int MEM_LAT = 1,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              mem_a_en,
  output logic [ADDR_W-1:0] mem_a_addr,
  input  logic [31:0]       mem_a_rdata,
  output logic              mem_b_en,
  output logic [ADDR_W-1:0] mem_b_addr,
  input  logic [31:0]       mem_b_rdata,
  output logic [31:0]       mac_a,
  output logic [31:0]       mac_b,
  output logic              mac_clear,
  output logic              mac_next,
  input  logic [64:0]       mac_psum,
  output logic [64:0]       result,
  output logic              result_valid,
  input  logic              result_ready
);
  localparam int P = MEM_LAT + MAC_LAT;
  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ba_q, bb_q;
  logic [LEN_W-1:0] len_q, idx;
  logic [P-1:0] sr;
  logic last, empty;
  assign last = idx == (len_q - LEN_W'(1));
  assign empty = sr == '0;
  assign busy = state != IDLE;
  assign mem_a_en = state == ISSUE;
  assign mem_b_en = state == ISSUE;
  assign mem_a_addr = ba_q + ADDR_W'(idx);
  assign mem_b_addr = bb_q + ADDR_W'(idx);
  assign mac_a = mem_a_rdata;
  assign mac_b = mem_b_rdata;
  assign mac_clear = state == CLEAR;
  assign mac_next = sr[P-1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   state_nx = (len_q == '0) ? DONE : ISSUE;
      ISSUE:   if (last) state_nx = DRAIN;
      DRAIN:   if (empty) state_nx = DONE;
      DONE:    if (result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // sr carries each read enable forward until the product it fetched reaches the accumulator
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ba_q <= '0;
      bb_q <= '0;
      len_q <= '0;
      idx <= '0;
      sr <= '0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      sr <= (sr << 1) | P'(mem_a_en);
      idx <= (state == ISSUE) ? idx + LEN_W'(1) : '0;
      if (state == IDLE && start) begin
        ba_q <= base_a;
        bb_q <= base_b;
        len_q <= len;
      end
      if (state == CLEAR && len_q == '0) begin
        result <= '0;
        result_valid <= 1'b1;
      end else if (state == DRAIN && empty) begin
        result <= mac_psum;
        result_valid <= 1'b1;
      end else if (state == DONE && result_ready) result_valid <= 1'b0;
    end
endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Control/feed stage directly upstream of the pipelined 32x32 multiply-accumulate unit in the PIM datapath.
- On a start command it reads two operand vectors of length N from two synchronous-read memory banks (A and B) and streams them onto the MAC's a/b inputs.
- It generates the MAC's clear/next controls aligned to the MAC's internal pipeline, then captures the final psum into a result register with a valid/ready handshake.

Parameters:
- ADDR_W, 10, address width of each operand bank
- LEN_W, 11, width of vector length input (N up to 2^LEN_W-1)
- MEM_LAT, 1, read latency of the banks in cycles (rdata valid MEM_LAT cycles after en)
- MAC_LAT, 2, MAC internal register stages between a/b and the accumulator (operand reg + multiply reg)

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_a  in  ADDR_W  first address of vector A
- base_b  in  ADDR_W  first address of vector B
- len  in  LEN_W  element count N
- busy  out  1  high in any state except IDLE
- mem_a_en  out  1  bank A read enable
- mem_a_addr  out  ADDR_W  bank A read address
- mem_a_rdata  in  32  bank A read data
- mem_b_en  out  1  bank B read enable
- mem_b_addr  out  ADDR_W  bank B read address
- mem_b_rdata  in  32  bank B read data
- mac_a  out  32  to MAC a; combinational pass-through of mem_a_rdata
- mac_b  out  32  to MAC b; combinational pass-through of mem_b_rdata
- mac_clear  out  1  to MAC clear
- mac_next  out  1  to MAC next
- mac_psum  in  65  from MAC psum
- result  out  65  captured dot product
- result_valid  out  1  result holds a new value
- result_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, any time including mid-operation): FSM to IDLE; busy, mem_*_en, mac_clear, mac_next, result_valid = 0; result = 0; addresses = 0; next-alignment pipeline flushed. Reset has no effect on memory or MAC contents.
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches base_a, base_b, len; -> CLEAR. Other inputs ignored.
- CLEAR (1 cycle): mac_clear=1, mac_next=0. If latched len=0 -> DONE with result=0. Otherwise -> ISSUE.
- ISSUE (N cycles, i=0..N-1): mem_a_en=mem_b_en=1; addr = base + i, wrapping modulo 2^ADDR_W. After i=N-1 -> DRAIN.
- Alignment: mac_next = read-enable delayed by MEM_LAT+MAC_LAT cycles, via a shift register. A read issued in cycle k asserts mac_next in cycle k+3 at defaults. mac_clear and mac_next are never high in the same cycle.
- DRAIN: wait until the alignment shift register is empty. Then wait one further cycle so psum reflects the last accumulate. In that cycle, capture result <= mac_psum, set result_valid=1, -> DONE.
- DONE: hold result and result_valid until result_ready=1. On that handshake edge, clear result_valid -> IDLE. start is ignored while busy.
- Latency (defaults, N>=1): start sampled at the end of cycle s; result_valid first high in cycle s+N+6. For N=0, result_valid is first high in cycle s+2.
- mac_a/mac_b carry don't-care data when no read is in flight. mac_next=0 in those cycles.
- result is the full 65-bit psum, unsigned. Overflow behaviour is the MAC's; this block does not saturate.

Test Plan:
- Reset mid-ISSUE (N=8, assert reset_n=0 at 3rd read) -> all outputs 0 immediately, no further mem_*_en; a new start then runs a clean vector.
- A=[1,2,3,4], B=[5,6,7,8], base_a=0, base_b=16, len=4, start at cycle 0 -> addresses 0..3 / 16..19 in cycles 2..5; mac_next high cycles 5..8; result_valid at cycle 10; result=70.
- len=1, A=[0xFFFFFFFF], B=[0xFFFFFFFF] -> result=0xFFFFFFFE00000001, result_valid at cycle 7.
- len=0 -> one mac_clear pulse, no reads, result=0, result_valid at cycle 2.
- base_a=0x3FE, len=4 -> A addresses 0x3FE, 0x3FF, 0x000, 0x001; product sum matches the model.
- Back-pressure: hold result_ready=0 for 20 cycles and pulse start during DONE -> result stable, start ignored, busy=1. Release ready -> IDLE next cycle; a second vector starts with mac_clear so no carry-over from the previous sum.
